// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - round-robin unified instruction/data memory responder with fixed wait states
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        busy,
    output logic        err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic       PORT_IF  = 1'b0;
    localparam logic       PORT_D   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 port_q, port_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          if_rdata_q, if_rdata_d;
    logic [31:0]          d_rdata_q, d_rdata_d;
    logic                 err_q, err_d;
    logic                 mem_we;
    logic [31:0]          mem_q [DEPTH];

    logic                 if_pend;
    logic                 d_pend;
    logic                 grant_d_port;
    logic [ADDR_BITS+1:0] grant_addr;

    // Address bits above the array size are deliberately ignored (wrap-around).
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_BITS+2], d_addr[31:ADDR_BITS+2]};

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= PORT_D;
            port_q       <= PORT_IF;
            is_wr_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            is_wr_q      <= is_wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    // Word array: not reset so preloaded contents survive; writes commit on the last wait edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Arbitration, wait-state counting and access sequencing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        is_wr_d      = is_wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        mem_we       = 1'b0;
        if_pend      = if_req;
        d_pend       = d_rd | d_wr;
        grant_d_port = 1'b0;
        grant_addr   = if_addr[ADDR_BITS+1:0];

        case (state_q)
            IDLE: begin
                if (if_pend || d_pend) begin
                    // On contention the port that lost last time wins.
                    if (if_pend && d_pend) begin
                        grant_d_port = (last_grant_q == PORT_IF);
                    end else begin
                        grant_d_port = d_pend;
                    end
                    grant_addr = grant_d_port ? d_addr[ADDR_BITS+1:0]
                                              : if_addr[ADDR_BITS+1:0];
                    port_d  = grant_d_port;
                    is_wr_d = grant_d_port & d_wr;
                    idx_d   = grant_addr[ADDR_BITS+1:2];
                    wdata_d = d_wdata;
                    cnt_d   = CNT_LOAD;
                    if ((grant_addr[1:0] != 2'b00) || (grant_d_port && d_rd && d_wr)) begin
                        err_d = 1'b1;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else if (port_q == PORT_D) begin
                        d_rdata_d = mem_q[idx_q];
                    end else begin
                        if_rdata_d = mem_q[idx_q];
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Unconditional turnaround so a still-held request is not re-granted.
                last_grant_d = port_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_ack   = (state_q == RESP) && (port_q == PORT_IF);
    assign d_ack    = (state_q == RESP) && (port_q == PORT_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with randomized accesses
module tb_mem_responder;

    localparam int   AB   = 10;
    localparam int   LAT  = 2;
    localparam logic P_IF = 1'b0;
    localparam logic P_D  = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        logic        port;
        logic [31:0] if_rd;
        logic [31:0] d_rd;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] ref_if_rdata = 32'd0;
    logic [31:0] ref_d_rdata  = 32'd0;
    logic        ref_err      = 1'b0;
    logic        prev_ack     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AB));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (if_ack || d_ack) begin
            check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
            check("ack_one_cycle", 32'(prev_ack), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with no pending expectation", if_ack, d_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", 32'(d_ack), 32'(e.port));
                check("if_rdata", if_rdata, e.if_rd);
                check("d_rdata", d_rdata, e.d_rd);
            end
        end
        prev_ack = if_ack | d_ack;
    end

    task automatic reset_dut();
        reset  = 1'b1;
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset        = 1'b0;
        ref_if_rdata = 32'd0;
        ref_d_rdata  = 32'd0;
        ref_err      = 1'b0;
        @(negedge clk);
    endtask

    task automatic xact(input logic port, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   n;
        int   w;
        logic seen;
        w = widx(addr);
        if (port == P_IF) begin
            ref_if_rdata = ref_mem[w];
        end else if (wr) begin
            ref_mem[w] = wdata;
        end else begin
            ref_d_rdata = ref_mem[w];
        end
        if ((addr[1:0] != 2'b00) || (port == P_D && rd && wr)) ref_err = 1'b1;
        e.port  = port;
        e.if_rd = ref_if_rdata;
        e.d_rd  = ref_d_rdata;
        exp_q.push_back(e);
        if (port == P_IF) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_rd    = rd;
            d_wr    = wr;
            d_addr  = addr;
            d_wdata = wdata;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_rise", 32'(busy), 32'd1);
            seen = (port == P_IF) ? if_ack : d_ack;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required within %0d", n, LAT + 1);
        end else begin
            check("ack_latency", 32'(n), 32'(LAT + 1));
        end
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(ref_err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        int          n;
        int          acks;
        exp_t        e;

        reset_dut();

        // Preload word 3, then fetch it and confirm the data holds afterwards.
        xact(P_D, 1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF);
        xact(P_IF, 1'b0, 1'b0, 32'h0000_000C, 32'd0);
        repeat (3) @(negedge clk);
        check("if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Data write then read back.
        xact(P_D, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        xact(P_D, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        check("d_rdata_direct", d_rdata, 32'h1234_5678);

        // Upper address bits wrap.
        xact(P_IF, 1'b0, 1'b0, 32'h0000_100C, 32'd0);
        check("wrap_fetch", if_rdata, 32'hDEAD_BEEF);

        // Randomized traffic over a small window with random upper address bits.
        for (int k = 0; k < 16; k++) begin
            xact(P_D, 1'b0, 1'b1, 32'(k * 4) | ($urandom & 32'hFFFF_F000), $urandom);
        end
        for (int k = 0; k < 40; k++) begin
            a   = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            sel = $urandom_range(0, 2);
            if (sel == 0)      xact(P_IF, 1'b0, 1'b0, a, 32'd0);
            else if (sel == 1) xact(P_D, 1'b1, 1'b0, a, 32'd0);
            else               xact(P_D, 1'b0, 1'b1, a, $urandom);
        end

        // Both ports held from reset: grants must alternate starting with fetch.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) ref_if_rdata = ref_mem[3];
            else            ref_d_rdata  = ref_mem[16];
            e.port  = (k % 2 == 1);
            e.if_rd = ref_if_rdata;
            e.d_rd  = ref_d_rdata;
            exp_q.push_back(e);
        end
        if_addr = 32'h0000_000C;
        d_addr  = 32'h0000_0040;
        if_req  = 1'b1;
        d_rd    = 1'b1;
        n       = 0;
        acks    = 0;
        while (acks < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (if_ack || d_ack) acks++;
        end
        if_req = 1'b0;
        d_rd   = 1'b0;
        check("contention_acks", 32'(acks), 32'd4);
        repeat (2) @(negedge clk);
        check("contention_drained", 32'(exp_q.size()), 32'd0);

        // Read and write together is a write and flags an error that sticks.
        xact(P_D, 1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D);
        xact(P_D, 1'b1, 1'b0, 32'h0000_0008, 32'd0);
        xact(P_IF, 1'b0, 1'b0, 32'h0000_0040, 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Misaligned fetch still returns the word and flags an error.
        reset_dut();
        xact(P_IF, 1'b0, 1'b0, 32'h0000_000D, 32'd0);
        check("misaligned_err", 32'(err), 32'd1);

        // Reset during the wait of a write drops the write.
        reset_dut();
        xact(P_D, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_0008);
        d_wr    = 1'b1;
        d_addr  = 32'h0000_0020;
        d_wdata = 32'h5555_AAAA;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        reset_dut();
        xact(P_D, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        check("abort_word8", d_rdata, 32'h0BAD_0008);

        repeat (3) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
